// File: rtl/mem_access_ctrl.sv
// Purpose : sequence LC-3 MAR/MDR accesses onto an asynchronous SRAM with fixed wait states.
// Latency : read done RD_WAIT+1 cycles after the accepting edge, write done WR_WAIT+2 cycles after it.
// Backpr. : ready=1 only in IDLE; a request made while busy is discarded and flagged on req_dropped.
//
// Ports
//   Clk, Reset_n       clock (rising edge), asynchronous active-low reset
//   req_rd, req_wr     one-cycle request pulses from the control FSM (read has priority)
//   mar_in, mdr_in     address / write data, sampled when the request is accepted
//   sram_rdata         SRAM read data
//   sram_addr/_wdata   latched address and write data towards the SRAM
//   sram_wdata_oe      drive enable for the shared SRAM data bus
//   CE_n, OE_n, WE_n   active-low SRAM strobes
//   mem_rdata          registered read word for the MDR input mux
//   mdr_sel, ld_mdr_mem MDR mux select (0 = memory) and load strobe for read data
//   ready, done        idle indication and one-cycle completion pulse
//   req_dropped        one-cycle pulse, a request arrived while busy
module mem_access_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] mar_in,
  input  logic [15:0] mdr_in,
  input  logic [15:0] sram_rdata,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_wdata_oe,
  output logic        CE_n,
  output logic        OE_n,
  output logic        WE_n,
  output logic [15:0] mem_rdata,
  output logic        mdr_sel,
  output logic        ld_mdr_mem,
  output logic        ready,
  output logic        done,
  output logic        req_dropped
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  // Counter values on the final cycle of each timed phase.
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACT   = 3'd1,
    ST_RD_CAP   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Every output is assigned together with the state it belongs to, so
  // the strobes are pure flops: nothing from req_* reaches the SRAM pins
  // without passing through a register first.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_wdata_oe <= 1'b0;
      CE_n          <= 1'b1;
      OE_n          <= 1'b1;
      WE_n          <= 1'b1;
      mem_rdata     <= '0;
      mdr_sel       <= 1'b1;
      ld_mdr_mem    <= 1'b0;
      ready         <= 1'b1;
      done          <= 1'b0;
      req_dropped   <= 1'b0;
    end else begin
      // Single-cycle pulses default low; the RD_CAP / WR_HOLD entries raise them.
      done        <= 1'b0;
      ld_mdr_mem  <= 1'b0;
      mdr_sel     <= 1'b1;
      // Any request while not idle is lost; the access in flight carries on.
      req_dropped <= (state != ST_IDLE) && (req_rd || req_wr);

      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (req_rd) begin
            // Read wins over a simultaneous write; the write is discarded
            // without a req_dropped pulse since the port was ready.
            state         <= ST_RD_ACT;
            sram_addr     <= mar_in;
            sram_wdata_oe <= 1'b0;
            CE_n          <= 1'b0;
            OE_n          <= 1'b0;
            WE_n          <= 1'b1;
            ready         <= 1'b0;
          end else if (req_wr) begin
            state         <= ST_WR_SETUP;
            sram_addr     <= mar_in;
            sram_wdata    <= mdr_in;
            sram_wdata_oe <= 1'b1;
            CE_n          <= 1'b0;
            OE_n          <= 1'b1;
            WE_n          <= 1'b1;
            ready         <= 1'b0;
          end else begin
            sram_wdata_oe <= 1'b0;
            CE_n          <= 1'b1;
            OE_n          <= 1'b1;
            WE_n          <= 1'b1;
            ready         <= 1'b1;
          end
        end

        ST_RD_ACT: begin
          if (wait_cnt == RD_LAST) begin
            // Sample the SRAM at the end of the last wait cycle; CE_n/OE_n
            // stay low through RD_CAP so the word remains valid there too.
            state      <= ST_RD_CAP;
            wait_cnt   <= '0;
            mem_rdata  <= sram_rdata;
            ld_mdr_mem <= 1'b1;
            mdr_sel    <= 1'b0;
            done       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        ST_RD_CAP: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          CE_n     <= 1'b1;
          OE_n     <= 1'b1;
          ready    <= 1'b1;
        end

        ST_WR_SETUP: begin
          // Address and data have had one cycle to settle before WE_n falls.
          state    <= ST_WR_PULSE;
          wait_cnt <= '0;
          WE_n     <= 1'b0;
        end

        ST_WR_PULSE: begin
          if (wait_cnt == WR_LAST) begin
            // WE_n rises one cycle before data/CE release for hold time.
            state    <= ST_WR_HOLD;
            wait_cnt <= '0;
            WE_n     <= 1'b1;
            done     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        ST_WR_HOLD: begin
          state         <= ST_IDLE;
          wait_cnt      <= '0;
          CE_n          <= 1'b1;
          sram_wdata_oe <= 1'b0;
          ready         <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          wait_cnt      <= '0;
          sram_wdata_oe <= 1'b0;
          CE_n          <= 1'b1;
          OE_n          <= 1'b1;
          WE_n          <= 1'b1;
          ready         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_rd, req_wr;
  logic [15:0] mar_in, mdr_in, sram_rdata;

  logic [15:0] sram_addr, sram_wdata, mem_rdata;
  logic        sram_wdata_oe, CE_n, OE_n, WE_n, mdr_sel, ld_mdr_mem, ready, done, req_dropped;

  // Second instance with a single read wait state, sharing all inputs.
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        b_woe, b_ce_n, b_oe_n, b_we_n, b_sel, b_ld, b_ready, b_done, b_drop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.RD_WAIT(2), .WR_WAIT(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .mar_in(mar_in), .mdr_in(mdr_in), .sram_rdata(sram_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .mem_rdata(mem_rdata),
    .mdr_sel(mdr_sel), .ld_mdr_mem(ld_mdr_mem), .ready(ready), .done(done),
    .req_dropped(req_dropped)
  );

  mem_access_ctrl #(.RD_WAIT(1), .WR_WAIT(2)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .mar_in(mar_in), .mdr_in(mdr_in), .sram_rdata(sram_rdata),
    .sram_addr(b_addr), .sram_wdata(b_wdata), .sram_wdata_oe(b_woe),
    .CE_n(b_ce_n), .OE_n(b_oe_n), .WE_n(b_we_n), .mem_rdata(b_rdata),
    .mdr_sel(b_sel), .ld_mdr_mem(b_ld), .ready(b_ready), .done(b_done),
    .req_dropped(b_drop)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: an accepted access is expanded into the list of
  // per-cycle pin patterns it must produce; idle cycles use the idle pattern.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic ce_n, oe_n, we_n, woe, ld, sel, dn, rdy;
  } obs_t;

  localparam obs_t P_IDLE  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam obs_t P_RDACT = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam obs_t P_RDCAP = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam obs_t P_WRSET = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam obs_t P_WRPUL = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam obs_t P_WRHLD = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  obs_t        plan[$];
  obs_t        m_cur;
  logic        m_drop;
  logic [15:0] m_addr, m_wdata, m_rdata;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      plan.delete();
      m_cur   = P_IDLE;
      m_drop  = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
    end else begin
      m_drop = !m_cur.rdy && (req_rd || req_wr);
      if (m_cur.rdy && req_rd) begin
        m_addr = mar_in;
        for (int k = 0; k < 2; k++) plan.push_back(P_RDACT);
        plan.push_back(P_RDCAP);
      end else if (m_cur.rdy && req_wr) begin
        m_addr  = mar_in;
        m_wdata = mdr_in;
        plan.push_back(P_WRSET);
        for (int k = 0; k < 2; k++) plan.push_back(P_WRPUL);
        plan.push_back(P_WRHLD);
      end
      if (plan.size() > 0) begin
        m_cur = plan.pop_front();
        if (m_cur.ld) m_rdata = sram_rdata;
      end else begin
        m_cur = P_IDLE;
      end
    end
  end

  // Cycle-by-cycle comparison, half a period away from the active edge.
  always @(negedge Clk) begin
    obs_t d;
    d = '{CE_n, OE_n, WE_n, sram_wdata_oe, ld_mdr_mem, mdr_sel, done, ready};
    check("cycle", {7'd0, d, req_dropped, sram_addr, sram_wdata, mem_rdata},
                   {7'd0, m_cur, m_drop, m_addr, m_wdata, m_rdata});
  end

  // ---------------------------------------------------------------------
  // Directed scenarios with hand-computed observations
  // ---------------------------------------------------------------------
  int w_ce, w_oe, w_woe, w_we_first, w_we_last, w_done_first, w_done_last, w_ndone, w_drop;
  int w_b_done_first, w_b_done_last;

  // Cycle i (1..n) is the cycle after the i-th rising edge following the
  // request drive; an extra request can be injected during cycle inj.
  task automatic watch(input int n, input int inj, input logic inj_rd, input logic inj_wr);
    w_ce = 0; w_oe = 0; w_woe = 0; w_we_first = 0; w_we_last = 0;
    w_done_first = 0; w_done_last = 0; w_ndone = 0; w_drop = 0;
    w_b_done_first = 0; w_b_done_last = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge Clk); #1;
      req_rd = 1'b0;
      req_wr = 1'b0;
      if (i == inj) begin
        req_rd = inj_rd;
        req_wr = inj_wr;
      end
      if (!CE_n) w_ce++;
      if (!OE_n) w_oe++;
      if (sram_wdata_oe) w_woe++;
      if (!WE_n) begin
        if (w_we_first == 0) w_we_first = i;
        w_we_last = i;
      end
      if (done) begin
        if (w_done_first == 0) w_done_first = i;
        w_done_last = i;
        w_ndone++;
      end
      if (req_dropped && w_drop == 0) w_drop = i;
      if (b_done) begin
        if (w_b_done_first == 0) w_b_done_first = i;
        w_b_done_last = i;
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    mar_in = '0; mdr_in = '0; sram_rdata = '0;
    #12;
    check("rst_strobes", {CE_n, OE_n, WE_n, sram_wdata_oe}, 4'b1110);
    check("rst_flags", {mdr_sel, ld_mdr_mem, ready, done, req_dropped}, 5'b10100);
    check("rst_data", {sram_addr, sram_wdata, mem_rdata}, 48'd0);
    #11 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // 1: plain read
    mar_in = 16'h3000; sram_rdata = 16'hBEEF; req_rd = 1'b1;
    watch(5, 0, 1'b0, 1'b0);
    check("rd_ce_cycles", w_ce, 3);
    check("rd_oe_cycles", w_oe, 3);
    check("rd_done_cycle", w_done_first, 3);
    check("rd_data", mem_rdata, 16'hBEEF);
    check("rd_addr", sram_addr, 16'h3000);
    check("rd_wait1_done_cycle", w_b_done_first, 2);

    // 2: plain write
    mar_in = 16'h0010; mdr_in = 16'h1234; req_wr = 1'b1;
    watch(6, 0, 1'b0, 1'b0);
    check("wr_woe_cycles", w_woe, 4);
    check("wr_we_window", {w_we_first, w_we_last}, {32'd2, 32'd3});
    check("wr_done_cycle", w_done_first, 4);
    check("wr_oe_cycles", w_oe, 0);
    check("wr_wdata", sram_wdata, 16'h1234);
    check("wr_keeps_rdata", mem_rdata, 16'hBEEF);

    // 3: simultaneous requests, read wins silently
    mar_in = 16'h2222; mdr_in = 16'h5555; sram_rdata = 16'h0F0F;
    req_rd = 1'b1; req_wr = 1'b1;
    watch(5, 0, 1'b0, 1'b0);
    check("both_done_cycle", w_done_first, 3);
    check("both_we_low", w_we_first, 0);
    check("both_dropped", w_drop, 0);
    check("both_data", mem_rdata, 16'h0F0F);

    // 4: write request during RD_ACT is dropped
    mar_in = 16'h4000; sram_rdata = 16'hCAFE; req_rd = 1'b1;
    watch(5, 1, 1'b0, 1'b1);
    check("drop_cycle", w_drop, 2);
    check("drop_rd_done_cycle", w_done_first, 3);
    check("drop_rd_ndone", w_ndone, 1);
    check("drop_we_low", w_we_first, 0);
    check("drop_rd_data", mem_rdata, 16'hCAFE);

    // 6: read issued in the cycle right after a write's done
    mar_in = 16'h0020; mdr_in = 16'h5678; sram_rdata = 16'h1111; req_wr = 1'b1;
    watch(10, 5, 1'b1, 1'b0);
    check("b2b_done_cycles", {w_done_first, w_done_last}, {32'd4, 32'd8});
    check("b2b_ndone", w_ndone, 2);
    check("b2b_oe_cycles", w_oe, 3);
    check("b2b_rd_data", mem_rdata, 16'h1111);
    check("b2b_wait1_done", {w_b_done_first, w_b_done_last}, {32'd4, 32'd7});

    // 5: reset in the middle of WR_PULSE
    mar_in = 16'h0040; mdr_in = 16'h9999; req_wr = 1'b1;
    watch(2, 0, 1'b0, 1'b0);
    check("pulse_we_low", WE_n, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_strobes", {CE_n, WE_n, sram_wdata_oe}, 3'b110);
    check("rst_mid_ready", {ready, done}, 2'b10);
    @(posedge Clk); #3 Reset_n = 1'b1;
    watch(5, 0, 1'b0, 1'b0);
    check("rst_mid_no_done", w_ndone, 0);
    check("rst_mid_ready_after", ready, 1'b1);
    check("rst_mid_addr", sram_addr, 16'h0000);

    @(posedge Clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
